// File: rtl/zero_pad_stream.sv
// Streaming zero padder: IN_H x IN_W x CH map in, padded map out, valid/ready both sides.
// Define ZERO_PAD_FILL_EN to add a pad_value port (sampled at start) used as the fill.
module zero_pad_stream #(
    parameter int DATA_W = 32,
    parameter int IN_H   = 5,
    parameter int IN_W   = 5,
    parameter int CH     = 1,
    parameter int PAD_T  = 0,
    parameter int PAD_B  = 4,
    parameter int PAD_L  = 0,
    parameter int PAD_R  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef ZERO_PAD_FILL_EN
    input  logic [DATA_W-1:0] pad_value,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              done
);

    localparam int OW  = PAD_L + IN_W + PAD_R;
    localparam int OH  = PAD_T + IN_H + PAD_B;
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int CLW = (OW > 1) ? $clog2(OW) : 1;
    localparam int RWW = (OH > 1) ? $clog2(OH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, nxt;

    logic [CHW-1:0]    ch_q;
    logic [CLW-1:0]    col_q;
    logic [RWW-1:0]    row_q;
    logic [DATA_W-1:0] fill;
    logic              run;
    logic              is_data;
    logic              ch_last;
    logic              col_last;
    logic              row_last;
    logic              eol_n;
    logic              open;
    logic              adv;
    int                row_i;
    int                col_i;

`ifdef ZERO_PAD_FILL_EN
    logic [DATA_W-1:0] fill_q;
    assign fill = fill_q;
`else
    assign fill = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = S_RUN;
            S_RUN:   if (out_valid && out_ready && out_eof) nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        run  = (state == S_RUN);
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_comb begin
        row_i   = int'(row_q);
        col_i   = int'(col_q);
        is_data = (row_i >= PAD_T) && (row_i < PAD_T + IN_H) &&
                  (col_i >= PAD_L) && (col_i < PAD_L + IN_W);
    end

    assign ch_last  = (ch_q == CHW'(CH - 1));
    assign col_last = (col_q == CLW'(OW - 1));
    assign row_last = (row_q == RWW'(OH - 1));
    assign eol_n    = col_last && ch_last;

    // Once the eof beat is staged, counters have wrapped; hold off until it drains.
    assign open     = run && !out_eof && (!out_valid || out_ready);
    assign in_ready = open && is_data;
    assign adv      = open && (!is_data || in_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
`ifdef ZERO_PAD_FILL_EN
            fill_q    <= '0;
`endif
        end else begin
            if (state == S_IDLE && start) begin
                ch_q  <= '0;
                col_q <= '0;
                row_q <= '0;
`ifdef ZERO_PAD_FILL_EN
                fill_q <= pad_value;
`endif
            end
            if (adv) begin
                out_data  <= is_data ? in_data : fill;
                out_valid <= 1'b1;
                out_eol   <= eol_n;
                out_eof   <= eol_n && row_last;
                if (ch_last) begin
                    ch_q <= '0;
                    if (col_last) begin
                        col_q <= '0;
                        row_q <= row_last ? '0 : row_q + RWW'(1);
                    end else begin
                        col_q <= col_q + CLW'(1);
                    end
                end else begin
                    ch_q <= ch_q + CHW'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_eol   <= 1'b0;
                out_eof   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zero_pad_stream.sv
// Directed bench for zero_pad_stream: default 5x5 map and a 3x3x2 map padded by one.
// Covers streaming, backpressure, input bubbles, mid-frame reset and done/busy.
module tb_zero_pad_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start2;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        ir1, ov1, eol1, eof1, busy1, done1;
    logic [31:0] od1;
    logic        ir2, ov2, eol2, eof2, busy2, done2;
    logic [31:0] od2;

    logic        sel;
    logic        ir, ov, eol, eof, bsy, dn;
    logic [31:0] od;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    zero_pad_stream dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_eol(eol1), .out_eof(eof1), .busy(busy1), .done(done1)
    );

    zero_pad_stream #(
        .IN_H(3), .IN_W(3), .CH(2),
        .PAD_T(1), .PAD_B(1), .PAD_L(1), .PAD_R(1)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .out_eol(eol2), .out_eof(eof2), .busy(busy2), .done(done2)
    );

    always_comb begin
        ir = sel ? ir2 : ir1;
        ov = sel ? ov2 : ov1;
        od = sel ? od2 : od1;
        eol = sel ? eol2 : eol1;
        eof = sel ? eof2 : eof1;
        bsy = sel ? busy2 : busy1;
        dn = sel ? done2 : done1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: all high; 1: out_ready toggles; 2: in_valid gaps
    task automatic run_frame(input bit s, input int mode, input int abort_at);
        int ih, iw, nch, pt, pl, ow, oh, total, nin;
        int idx, nb, bub, gap, cyc, k, c_ch, c, r;
        bit seen, fin, pstall;
        logic [31:0] pdata, ed;
        bit eeol, eeof;
        if (s) begin
            ih = 3; iw = 3; nch = 2; pt = 1; pl = 1; ow = 5; oh = 5;
        end else begin
            ih = 5; iw = 5; nch = 1; pt = 0; pl = 0; ow = 9; oh = 9;
        end
        total = ow * oh * nch;
        nin = ih * iw * nch;
        idx = 0; nb = 0; bub = 0; gap = 0; cyc = 0;
        seen = 0; fin = 0; pstall = 0; pdata = '0;
        sel = s;
        @(negedge clk);
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        while (!fin && cyc < 2000) begin
            if (pstall) chk("stall_hold", {31'd0, ov, od}, {31'd1, pdata});
            out_ready = (mode == 1) ? cyc[0] : 1'b1;
            in_valid = 1'b1;
            if (mode == 2 && ((idx == 7 && gap < 3) || idx >= nin)) in_valid = 1'b0;
            in_data = 32'(idx + 1);
            #1;
            if (mode == 2 && idx == 7 && gap < 3) begin
                chk("gap_in_ready", {63'd0, ir}, 64'd1);
                gap++;
            end
            if (abort_at >= 0 && nb == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_valid", {63'd0, ov}, 64'd0);
                chk("abort_data", {32'd0, od}, 64'd0);
                chk("abort_flags", {60'd0, eol, eof, bsy, ir}, 64'd0);
                #1;
                reset = 1'b1;
                in_valid = 1'b0;
                return;
            end
            if (ov && out_ready) begin
                k = nb;
                c_ch = k % nch;
                c = (k / nch) % ow;
                r = k / (nch * ow);
                ed = '0;
                if (r >= pt && r < pt + ih && c >= pl && c < pl + iw)
                    ed = 32'(((r - pt) * iw + (c - pl)) * nch + c_ch + 1);
                eeol = (c == ow - 1) && (c_ch == nch - 1);
                eeof = (k == total - 1);
                chk($sformatf("beat%0d", k), {30'd0, eol, eof, od}, {30'd0, eeol, eeof, ed});
                nb++;
                seen = 1;
                if (eof) fin = 1;
            end else if (seen && !ov) begin
                bub++;
            end
            if (in_valid && ir) idx++;
            pstall = ov && !out_ready;
            pdata = od;
            cyc++;
            @(negedge clk);
        end
        if (!fin) begin
            ncmp++;
            nerr++;
            $error("FAIL timeout observed=%0d beats expected=%0d", nb, total);
        end
        in_valid = 1'b0;
        chk("beat_count", 64'(nb), 64'(total));
        chk("in_count", 64'(idx), 64'(nin));
        chk("bubbles", 64'(bub), (mode == 2) ? 64'd3 : 64'd0);
        chk("done_pulse", {62'd0, dn, bsy}, 64'd3);
        @(negedge clk);
        chk("idle_after", {61'd0, dn, bsy, ov}, 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, ov1}, 64'd0);
        chk("rst_data", {32'd0, od1}, 64'd0);
        chk("rst_flags", {59'd0, eol1, eof1, busy1, done1, ir1}, 64'd0);
        chk("rst_dut2", {59'd0, ov2, eof2, busy2, done2, ir2}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, ir1}, 64'd0);

        run_frame(1'b0, 0, -1);
        run_frame(1'b0, 1, -1);
        run_frame(1'b0, 2, -1);
        run_frame(1'b0, 0, 30);
        @(negedge clk);
        chk("post_abort_idle", {62'd0, busy1, ov1}, 64'd0);
        run_frame(1'b0, 0, -1);
        run_frame(1'b1, 0, -1);
        run_frame(1'b1, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
